// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// rv32i_ctrl_pkg : shared encodings for the multi-cycle RV32I control FSM
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package rv32i_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_TRAP     = 4'd9;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
// ============================================================================
// multicycle_control_if : datapath <-> control FSM signal bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             pc_source;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             retire;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  // Datapath side: supplies IR fields and memory handshake, consumes controls
  modport master (
    output opcode, funct3, mem_ready,
    input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           retire, illegal, instret
  );

  modport slave (
    input  opcode, funct3, mem_ready,
    output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           retire, illegal, instret
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : main control FSM of the multi-cycle RV32I core
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module multicycle_control
  import rv32i_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  multicycle_control_if.slave  bus
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE)        state_d = S_MEMADR;
        else if (bus.opcode == OP_RTYPE)                             state_d = S_EXECUTE;
        else if (bus.opcode == OP_BRANCH && bus.funct3 == F3_BEQ)    state_d = S_BRANCH;
        else                                                         state_d = S_TRAP;
      end
      S_MEMADR:   state_d = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Outputs are a pure decode of the state; holding rst kills any request at once
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_REG;
    bus.alu_op        = ALUOP_ADD;
    bus.retire        = 1'b0;
    bus.illegal       = 1'b0;
    bus.instret       = '0;
    if (!rst) begin
      bus.instret = instret_q;
      case (state_q)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE:   bus.alu_src_b = SRCB_IMM;
        S_MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.retire     = 1'b1;
        end
        S_MEMWRITE: begin
          bus.mem_write = 1'b1;
          bus.iord      = 1'b1;
          bus.retire    = bus.mem_ready;
        end
        S_EXECUTE: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          bus.reg_write = 1'b1;
          bus.retire    = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = ALUOP_SUB;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 1'b1;
          bus.retire        = 1'b1;
        end
        S_TRAP:     bus.illegal = 1'b1;
        default:    bus.illegal = 1'b0;
      endcase
    end
  end

  // retire is never set in TRAP, so the count freezes there without extra logic
  assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, bus.retire};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences the shared ALU, the register file, PC/IR writes and the unified memory port for lw, sw, R-type (add/sub/and/or) and beq.
- Drives the 2-bit ALUOp consumed by the ALU operation decoder, stalls on memory handshakes, traps illegal opcodes, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  reset, synchronous and active-high
- opcode  in  7  instruction[6:0] taken from the IR register
- funct3  in  3  instruction[14:12] taken from the IR register
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified externally by ALU zero
- pc_source  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target)
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  latch memory data into IR
- mem_to_reg  out  1  register writeback source: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = immediate, 11 unused (never driven)
- alu_op  out  2  00 = add, 01 = sub (branch compare), 10 = R-type decode by funct
- retire  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  sticky trap flag
- instret  out  CNT_W  retired-instruction count

Behaviour:
- States:
  - FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, TRAP.
  - Moore outputs decoded from the state.
  - ir_write, pc_write (FETCH) and retire (MEMWRITE) are additionally gated by mem_ready.
- Reset:
  - While rst=1, all outputs are forced to 0 combinationally. This abandons any in-flight memory request in the same cycle.
  - State returns to FETCH, illegal=0 and instret=0.
  - The first cycle after rst falls is FETCH.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0.
  - ir_write = pc_write = mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTE
    - 1100011 with funct3=000 -> BRANCH
    - anything else -> TRAP
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next: opcode 0000011 -> MEMREAD, otherwise MEMWRITE.
- MEMREAD:
  - Outputs: mem_read=1, iord=1.
  - Wait for mem_ready, then go to MEMWB.
- MEMWB:
  - Outputs: reg_write=1, mem_to_reg=1, retire=1.
  - Next: FETCH.
- MEMWRITE:
  - Outputs: mem_write=1, iord=1, retire=mem_ready.
  - Wait for mem_ready, then go to FETCH.
- EXECUTE:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next: ALUWB.
- ALUWB:
  - Outputs: reg_write=1, mem_to_reg=0, retire=1.
  - Next: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1, retire=1.
  - Next: FETCH.
- TRAP:
  - illegal=1; all write/request outputs are 0.
  - Absorbing: the FSM leaves TRAP only through reset.
- Outputs in unnamed cases: any output not listed for a state is 0.
- Never allowed: mem_read and mem_write high in the same cycle.
- Latency with mem_ready always 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - beq: 3 cycles
  - Each memory wait cycle adds 1.
- instret:
  - Increments by 1 on every cycle with retire=1.
  - Wraps from all-ones to 0 without a flag.
  - Frozen in TRAP.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

Decomposition:
- Shared package (rv32i_ctrl_pkg) holds:
  - the state encoding (4-bit localparams)
  - opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH
  - ALUOp encodings: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - alu_src_b encodings
- No sub-module is needed: the FSM register, the output decode and the instret counter live in one file.

Test Plan:
- Reset, then opcode 0110011 with mem_ready=1 -> states FETCH, DECODE, EXECUTE, ALUWB; alu_op=10 in EXECUTE; reg_write=1 and retire=1 only in ALUWB; instret=1.
- Opcode 0000011 with mem_ready=0 for 3 cycles in MEMREAD -> 8 cycles total; mem_read and iord held at 1 throughout MEMREAD; reg_write with mem_to_reg=1 exactly once.
- Opcode 0100011 with mem_ready=1 -> 4 cycles; mem_write=1 for one cycle with iord=1; reg_write is never asserted.
- Opcode 1100011 with funct3=000 -> BRANCH asserts alu_op=01, pc_write_cond=1, pc_source=1; opcode 1100011 with funct3=001 -> TRAP with illegal=1; instret frozen; both persist until rst.
- Opcode 1111111 -> TRAP; rst pulse -> illegal=0, instret=0, state FETCH.
- rst asserted during MEMWRITE wait -> mem_write=0 in that same cycle; FETCH on the following cycle.
